bi_dot_engine: RTL and testbench

Dot-product engine that consumes the weight stream of one dual-port CNN weight ROM (`bi_mem*`: 16 words × 128 bits, eight signed 16-bit weights per word, final word partially filled) and multiplies it against a streamed activation vector. It drives both ROM address ports, so each accepted activation beat pairs with two ROM words. It returns one saturated Q-format neuron output plus the raw accumulator. It sits directly downstream of the weight ROM and upstream of the activation/requantisation stage.

---
 rtl/bi_dot_engine.sv | 198 +++++++++++++++++++
 tb/tb_bi_dot_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bi_dot_engine.sv
// Dot-product engine: streams paired weight-ROM words against an activation vector and
// returns a saturated Q-format neuron output plus the raw accumulator.
module bi_dot_engine #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_WEIGHTS = 122,
  parameter int ACC_WIDTH   = 40,
  parameter int FRAC_BITS   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic [ADDR_WIDTH-1:0]     addr_a,
  output logic [ADDR_WIDTH-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0]     q_a,
  input  logic [DATA_WIDTH-1:0]     q_b,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [2*DATA_WIDTH-1:0]   act_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [15:0]               res_data,
  output logic [ACC_WIDTH-1:0]      res_acc
);

  localparam int LANES = DATA_WIDTH / 16;
  localparam int BW    = ADDR_WIDTH - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sd32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32'sd32768);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed 16x16 product; the low 32 bits of the sign-extended product are exact.
  function automatic logic [31:0] mul16(input logic [15:0] w, input logic [15:0] a);
    logic [31:0] w_ext;
    logic [31:0] a_ext;
    w_ext = {{16{w[15]}}, w};
    a_ext = {{16{a[15]}}, a};
    return w_ext * a_ext;
  endfunction

  // Floor-shift the accumulator and clamp into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sh;
    logic [15:0] res;
    sh = acc >>> FRAC_BITS;
    if (sh > SAT_MAX) begin
      res = 16'h7FFF;
    end else if (sh < SAT_MIN) begin
      res = 16'h8000;
    end else begin
      res = sh[15:0];
    end
    return res;
  endfunction

  state_t state_r, state_s;
  logic [BW-1:0]                beat_r, beat_next_s;
  logic                         drain_cnt_r;
  logic                         hs_s;
  logic [2*LANES-1:0][31:0]     prod_s, prod_r;
  logic                         prod_vld_r;
  logic [ACC_WIDTH-1:0]         sum_s;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic                         busy_r, act_ready_r, res_valid_r;
  logic [15:0]                  res_data_r;
  logic [ACC_WIDTH-1:0]         res_acc_r;

  assign hs_s = (state_r == RUN) && act_valid;

  // Next beat; addresses come from it so the registered ROM output lines up with the current beat.
  always_comb begin
    beat_next_s = beat_r;
    if (state_r == IDLE) begin
      beat_next_s = '0;
    end else if (hs_s) begin
      beat_next_s = beat_r + 1'b1;
    end else begin
      beat_next_s = beat_r;
    end
  end

  assign addr_a = {beat_next_s, 1'b0};
  assign addr_b = {beat_next_s, 1'b1};

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (hs_s && (beat_r == {BW{1'b1}})) state_s = DRAIN;
        else                                state_s = RUN;
      end
      DRAIN: begin
        if (drain_cnt_r) state_s = DONE;
        else             state_s = DRAIN;
      end
      DONE: begin
        if (res_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Lane products; lanes whose weight index lies past the last valid weight are forced to zero.
  always_comb begin
    prod_s = '0;
    for (int e = 0; e < LANES; e++) begin
      if ((int'({beat_r, 1'b0}) * LANES + e) >= NUM_WEIGHTS) begin
        prod_s[e] = 32'd0;
      end else begin
        prod_s[e] = mul16(q_a[DATA_WIDTH-1-16*e -: 16], act_data[2*DATA_WIDTH-1-16*e -: 16]);
      end
      if ((int'({beat_r, 1'b1}) * LANES + e) >= NUM_WEIGHTS) begin
        prod_s[LANES+e] = 32'd0;
      end else begin
        prod_s[LANES+e] = mul16(q_b[DATA_WIDTH-1-16*e -: 16], act_data[DATA_WIDTH-1-16*e -: 16]);
      end
    end
  end

  // Stage-2 adder tree over the registered products.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < 2*LANES; k++) begin
      sum_s = sum_s + {{(ACC_WIDTH-32){prod_r[k][31]}}, prod_r[k]};
    end
  end

  // Control state, beat counter and drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      beat_r      <= '0;
      drain_cnt_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_next_s;
      drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
    end
  end

  // Product pipeline register and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r     <= '0;
      prod_vld_r <= 1'b0;
      acc_r      <= '0;
    end else begin
      prod_vld_r <= hs_s;
      if (hs_s) prod_r <= prod_s;
      else      prod_r <= prod_r;
      if ((state_r == IDLE) && start) acc_r <= '0;
      else if (prod_vld_r)            acc_r <= acc_r + sum_s;
      else                            acc_r <= acc_r;
    end
  end

  // Registered status flags and result capture on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      act_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= 16'h0000;
      res_acc_r   <= '0;
    end else begin
      busy_r      <= (state_s != IDLE);
      act_ready_r <= (state_s == RUN);
      res_valid_r <= (state_s == DONE);
      if ((state_r == DRAIN) && (state_s == DONE)) begin
        res_data_r <= sat16(acc_r);
        res_acc_r  <= acc_r;
      end else begin
        res_data_r <= res_data_r;
        res_acc_r  <= res_acc_r;
      end
    end
  end

  assign busy      = busy_r;
  assign act_ready = act_ready_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_acc   = res_acc_r;

endmodule

// File: tb/tb_bi_dot_engine.sv
// Directed bench for bi_dot_engine with a behavioural registered ROM and a golden dot-product model.
module tb_bi_dot_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy;
  logic [3:0]   addr_a, addr_b;
  logic [127:0] q_a, q_b;
  logic         act_valid;
  logic         act_ready;
  logic [255:0] act_data;
  logic         res_valid;
  logic         res_ready;
  logic [15:0]  res_data;
  logic [39:0]  res_acc;

  logic [127:0] rom [16];
  logic [255:0] acts [8];
  int checks = 0;
  int failures = 0;

  bi_dot_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_acc(res_acc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_a <= rom[addr_a];
    q_b <= rom[addr_b];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0] valid_w, input logic [15:0] masked_w);
    for (int j = 0; j < 128; j++)
      rom[j/8][127-16*(j%8) -: 16] = (j < 122) ? valid_w : masked_w;
  endtask

  task automatic fill_acts(input logic [15:0] v);
    for (int k = 0; k < 8; k++) acts[k] = {16{v}};
  endtask

  function automatic longint golden();
    longint s;
    int word, e;
    logic [127:0] wd;
    logic [255:0] ab;
    logic signed [15:0] w, a;
    s = 0;
    for (int j = 0; j < 122; j++) begin
      word = j / 8;
      e = j % 8;
      wd = rom[word];
      ab = acts[word/2];
      w = wd[127-16*e -: 16];
      a = (word % 2 == 0) ? ab[255-16*e -: 16] : ab[127-16*e -: 16];
      s += longint'(w) * longint'(a);
    end
    return s;
  endfunction

  function automatic logic [15:0] sat_model(input longint acc);
    longint sh;
    sh = acc >>> 8;
    if (sh > 32767)       return 16'h7FFF;
    else if (sh < -32768) return 16'h8000;
    else                  return sh[15:0];
  endfunction

  // Called at a negedge in IDLE; returns at the negedge where res_valid is seen.
  task automatic run_vec(input int stall_pct, input logic [39:0] exp_acc,
                         input logic [15:0] exp_data, output int cycles);
    int k, cyc, loop_cyc;
    logic v, hs;
    logic [3:0] ea;
    k = 0;
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < 8 && cyc < 200) begin
      v = ($urandom_range(99) >= stall_pct);
      act_valid = v;
      act_data = v ? acts[k] : {8{$urandom}};
      #1;
      hs = v & act_ready;
      ea = 4'((k + int'(hs)) * 2);
      chk("addr_a", 64'(addr_a), 64'(ea));
      chk("addr_b", 64'(addr_b), 64'(ea + 4'd1));
      @(negedge clk);
      cyc++;
      if (hs) k++;
    end
    act_valid = 1'b0;
    loop_cyc = cyc;
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    cycles = cyc;
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("latency", 64'(cyc), 64'(loop_cyc + 2));
    chk("res_acc", 64'(res_acc), 64'(exp_acc));
    chk("res_data", 64'(res_data), 64'(exp_data));
  endtask

  // Holds res_ready low with start asserted, then handshakes with start still high.
  task automatic finish_res(input int hold, input logic [15:0] exp_data);
    res_ready = 1'b0;
    start = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(exp_data));
      chk("hold_busy", 64'(busy), 64'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("no_restart", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(act_ready), 64'd0);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_data"}, 64'(res_data), 64'd0);
    chk({tag, "_acc"}, 64'(res_acc), 64'd0);
    chk({tag, "_addr_a"}, 64'(addr_a), 64'd0);
    chk({tag, "_addr_b"}, 64'(addr_b), 64'd1);
  endtask

  initial begin
    int cyc;
    longint g;
    rst_n = 1'b0;
    start = 1'b0;
    act_valid = 1'b0;
    act_data = '0;
    res_ready = 1'b0;
    load_rom(16'h0001, 16'h7FFF);
    fill_acts(16'h0100);
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Unit weights, masked slots large: 122 * 256.
    run_vec(0, 40'd31232, 16'h007A, cyc);
    chk("lat_min", 64'(cyc), 64'd10);
    finish_res(5, 16'h007A);

    // Saturate high.
    load_rom(16'h7FFF, 16'h7FFF);
    fill_acts(16'h7FFF);
    run_vec(0, 40'd130988507258, 16'h7FFF, cyc);
    finish_res(0, 16'h7FFF);

    // Saturate low.
    load_rom(16'h8000, 16'h8000);
    run_vec(0, 40'd968519122944, 16'h8000, cyc);
    finish_res(0, 16'h8000);

    // Random weights/activations with stalls against the golden model.
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 16; w++) rom[w] = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 8; k++) acts[k] = {8{$urandom}};
      g = golden();
      run_vec(40, 40'(g), sat_model(g), cyc);
      finish_res(1, sat_model(g));
    end

    // Reset after beat 4, then a clean run.
    load_rom(16'h0001, 16'h7FFF);
    fill_acts(16'h0100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      act_data = acts[k];
      @(negedge clk);
    end
    act_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(0, 40'd31232, 16'h007A, cyc);
    chk("post_rst_lat", 64'(cyc), 64'd10);

    // Back-to-back: start in the first IDLE cycle after the handshake.
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_idle", 64'(busy), 64'd0);
    run_vec(0, 40'd31232, 16'h007A, cyc);
    chk("b2b_lat", 64'(cyc), 64'd10);
    finish_res(0, 16'h007A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
